apb_proc_sequencer: RTL and testbench

Processor-side initiator for the APB master's processor bus. It accepts byte-wide read and write commands from a local command interface, queues them in a command FIFO, and issues them one at a time through the processor bus (start/sel/addr/wdata/wait_cycles). It waits for the master's `ready`, then returns read data through a response FIFO. It replaces testbench-driven processor stimulus, so APB transfers can be streamed back-to-back.

---
 rtl/apb_proc_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_apb_proc_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_proc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : apb_proc_sequencer
// Purpose : Queues byte-wide read/write commands and streams them one at a
//           time onto the APB master processor bus; read data returns through
//           a response FIFO. Optional watchdog: define APB_SEQ_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module apb_proc_sequencer #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [1:0] cmd_sel,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic [7:0] cmd_wait,
  output logic       pb_start,
  output logic       pb_write,
  output logic [1:0] pb_sel,
  output logic [7:0] pb_addr,
  output logic [7:0] pb_wdata,
  output logic [7:0] pb_wait_cycles,
  output logic       pb_reset,
  input  logic       pb_ready,
  input  logic [7:0] pb_rdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_sel,
  output logic       busy,
  output logic       err_sel,
  output logic       err_timeout
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam logic [CAW:0] CMD_FULL = (CAW+1)'(CMD_DEPTH);
  localparam logic [RAW:0] RSP_FULL = (RAW+1)'(RSP_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [26:0]  cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wp, cmd_rp;
  logic [CAW:0]   cmd_cnt, cmd_cnt_nxt;
  logic [26:0]  head;
  logic         cmd_push, cmd_pop, load, sel_bad;

  logic [9:0]   rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] rsp_wp, rsp_rp;
  logic [RAW:0]   rsp_cnt, rsp_cnt_nxt;
  logic         rsp_push, rsp_pop, rsp_full;
  logic         timeout_fire;

  assign head      = cmd_mem[cmd_rp];
  assign cmd_push  = cmd_valid && cmd_ready;
  assign rsp_full  = (rsp_cnt == RSP_FULL);
  assign rsp_valid = (rsp_cnt != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? rsp_mem[rsp_rp][7:0] : 8'd0;
  assign rsp_sel   = rsp_valid ? rsp_mem[rsp_rp][9:8] : 2'd0;
  assign pb_start  = (state == ISSUE);
  assign busy      = (state != IDLE) || (cmd_cnt != '0);

  always_comb begin
    state_nxt = state;
    cmd_pop   = 1'b0;
    load      = 1'b0;
    sel_bad   = 1'b0;
    rsp_push  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_cnt != '0) begin
          if (head[25:24] == 2'd0) begin
            cmd_pop = 1'b1;
            sel_bad = 1'b1;
          end else if (!(!head[26] && rsp_full)) begin
            cmd_pop   = 1'b1;
            load      = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (pb_ready) begin
          rsp_push  = !pb_write;
          state_nxt = DONE;
        end else if (timeout_fire) begin
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_cnt_nxt = cmd_cnt;
    if (cmd_push && !cmd_pop)      cmd_cnt_nxt = cmd_cnt + (CAW+1)'(1);
    else if (!cmd_push && cmd_pop) cmd_cnt_nxt = cmd_cnt - (CAW+1)'(1);
    rsp_cnt_nxt = rsp_cnt;
    if (rsp_push && !rsp_pop)      rsp_cnt_nxt = rsp_cnt + (RAW+1)'(1);
    else if (!rsp_push && rsp_pop) rsp_cnt_nxt = rsp_cnt - (RAW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_wp    <= '0;
      cmd_rp    <= '0;
      cmd_cnt   <= '0;
      cmd_ready <= 1'b0;
      rsp_wp    <= '0;
      rsp_rp    <= '0;
      rsp_cnt   <= '0;
      err_sel   <= 1'b0;
      pb_reset  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (cmd_push) begin
        cmd_mem[cmd_wp] <= {cmd_write, cmd_sel, cmd_addr, cmd_wdata, cmd_wait};
        cmd_wp          <= cmd_wp + CAW'(1);
      end
      if (cmd_pop) cmd_rp <= cmd_rp + CAW'(1);
      cmd_cnt   <= cmd_cnt_nxt;
      // Registered not-full: a pop while full reopens the port on the next cycle.
      cmd_ready <= (cmd_cnt_nxt != CMD_FULL);
      if (rsp_push) begin
        rsp_mem[rsp_wp] <= {pb_sel, pb_rdata};
        rsp_wp          <= rsp_wp + RAW'(1);
      end
      if (rsp_pop) rsp_rp <= rsp_rp + RAW'(1);
      rsp_cnt  <= rsp_cnt_nxt;
      if (sel_bad) err_sel <= 1'b1;
      pb_reset <= timeout_fire;
    end
  end

  // Transfer fields hold through DONE; only the slave select drops back in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pb_write       <= 1'b0;
      pb_sel         <= 2'd0;
      pb_addr        <= 8'd0;
      pb_wdata       <= 8'd0;
      pb_wait_cycles <= 8'd0;
    end else if (load) begin
      pb_write       <= head[26];
      pb_sel         <= head[25:24];
      pb_addr        <= head[23:16];
      pb_wdata       <= head[15:8];
      pb_wait_cycles <= head[7:0];
    end else if (state != IDLE && state_nxt == IDLE) begin
      pb_sel <= 2'd0;
    end
  end

`ifdef APB_SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt;

  assign timeout_fire = (state == WAIT) && !pb_ready && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt      <= 16'd0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ISSUE)     wd_cnt <= 16'd0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 16'd1;
      if (timeout_fire) err_timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^(16'(TIMEOUT));
  assign timeout_fire   = 1'b0;
  assign err_timeout    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_proc_sequencer.sv
`default_nettype none
// Directed bench for apb_proc_sequencer; the slave model returns rdata = addr ^ 0x7C.
module tb_apb_proc_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [1:0] cmd_sel;
  logic [7:0] cmd_addr, cmd_wdata, cmd_wait;
  logic       pb_start, pb_write, pb_reset, pb_ready;
  logic [1:0] pb_sel;
  logic [7:0] pb_addr, pb_wdata, pb_wait_cycles, pb_rdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_sel;
  logic       busy, err_sel, err_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int resp_delay = 3;
  logic resp_en = 1'b0;
  logic kick = 1'b0;
  int s0;
  int nw;
  logic [7:0] exp_rd [4] = '{8'h7E, 8'h7F, 8'h78, 8'h79};

  apb_proc_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wait(cmd_wait),
    .pb_start(pb_start), .pb_write(pb_write), .pb_sel(pb_sel), .pb_addr(pb_addr),
    .pb_wdata(pb_wdata), .pb_wait_cycles(pb_wait_cycles), .pb_reset(pb_reset),
    .pb_ready(pb_ready), .pb_rdata(pb_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_sel(rsp_sel),
    .busy(busy), .err_sel(err_sel), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Slave model: answers resp_delay cycles after a start, or once on demand via kick.
  initial begin
    pb_ready = 1'b0;
    pb_rdata = 8'd0;
    forever begin
      @(posedge clk); #1;
      pb_ready = 1'b0;
      if (kick) begin
        pb_ready = 1'b1;
        pb_rdata = pb_addr ^ 8'h7C;
        kick     = 1'b0;
      end else if (pb_start && resp_en) begin
        repeat (resp_delay) begin @(posedge clk); #1; end
        pb_ready = 1'b1;
        pb_rdata = pb_addr ^ 8'h7C;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (pb_start) start_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input logic w, input logic [1:0] s, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] wt);
    int n = 0;
    while (!cmd_ready && n < 60) begin @(negedge clk); n++; end
    check("push_ready", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_sel = s; cmd_addr = a; cmd_wdata = d; cmd_wait = wt;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin @(negedge clk); n++; end
    check("idle_reached", int'(busy), 0);
  endtask

  task automatic wait_start(input int max);
    int n = 0;
    while (!pb_start && n < max) begin @(negedge clk); n++; end
    check("start_seen", int'(pb_start), 1);
  endtask

  task automatic pop_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sel = 2'd0;
    cmd_addr = 8'd0; cmd_wdata = 8'd0; cmd_wait = 8'd0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_pb_reset", int'(pb_reset), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_start", int'(pb_start), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_err", int'({err_sel, err_timeout}), 0);
    check("rst_fields", int'({pb_write, pb_sel, pb_addr, pb_wdata, pb_wait_cycles}), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", int'(cmd_ready), 1);
    check("rel_pb_reset", int'(pb_reset), 0);

    // Single write, ready three cycles after start
    resp_en = 1'b1; resp_delay = 3; s0 = start_cnt;
    push(1'b1, 2'd1, 8'h10, 8'hA5, 8'h00);
    check("w_start_pre", int'(pb_start), 0);
    @(negedge clk);
    check("w_start", int'(pb_start), 1);
    check("w_fields", int'({pb_write, pb_sel, pb_addr, pb_wdata, pb_wait_cycles}),
          int'({1'b1, 2'd1, 8'h10, 8'hA5, 8'h00}));
    @(negedge clk);
    check("w_pulse_one", int'(pb_start), 0);
    check("w_hold", int'({pb_sel, pb_addr, pb_wdata}), int'({2'd1, 8'h10, 8'hA5}));
    wait_idle(20);
    check("w_sel_idle", int'(pb_sel), 0);
    check("w_addr_keep", int'(pb_addr), 'h10);
    check("w_no_rsp", int'(rsp_valid), 0);
    check("w_starts", start_cnt - s0, 1);

    // Single read, response held until popped
    resp_delay = 2;
    push(1'b0, 2'd2, 8'h20, 8'h00, 8'h03);
    @(negedge clk);
    check("r_wait_cycles", int'(pb_wait_cycles), 3);
    nw = 0;
    while (!pb_ready && nw < 20) begin @(negedge clk); nw++; end
    check("r_ready_seen", int'(pb_ready), 1);
    check("r_no_bypass", int'(rsp_valid), 0);
    @(negedge clk);
    check("r_valid", int'(rsp_valid), 1);
    check("r_data", int'(rsp_data), 'h5C);
    check("r_sel", int'(rsp_sel), 2);
    repeat (4) @(negedge clk);
    check("r_held", int'({rsp_valid, rsp_data}), int'({1'b1, 8'h5C}));
    pop_rsp();
    check("r_popped", int'(rsp_valid), 0);
    wait_idle(20);

    // sel=0 command is dropped, next one issues
    s0 = start_cnt;
    push(1'b1, 2'd0, 8'h33, 8'h44, 8'h00);
    push(1'b1, 2'd1, 8'h11, 8'h22, 8'h00);
    check("e_err_sel", int'(err_sel), 1);
    check("e_no_start", int'(pb_start), 0);
    @(negedge clk);
    check("e_start", int'(pb_start), 1);
    check("e_addr", int'(pb_addr), 'h11);
    wait_idle(20);
    check("e_starts", start_cnt - s0, 1);
    check("e_sticky", int'(err_sel), 1);

    // Command FIFO fills while one transfer is stuck in WAIT
    resp_en = 1'b0; s0 = start_cnt;
    push(1'b1, 2'd1, 8'h40, 8'h00, 8'h00);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) push(1'b1, 2'd1, 8'(8'h40 + i), 8'h00, 8'h00);
    check("f_full", int'(cmd_ready), 0);
`ifndef APB_SEQ_TIMEOUT_EN
    repeat (12) @(negedge clk);
    check("f_no_wd", int'({err_timeout, pb_reset}), 0);
    check("f_still_busy", int'(busy), 1);
`endif
    resp_en = 1'b1; resp_delay = 1; kick = 1'b1;
    @(negedge clk);
    check("f_still_full", int'(cmd_ready), 0);
    wait_start(10);
    check("f_next_addr", int'(pb_addr), 'h41);
    check("f_reopen", int'(cmd_ready), 1);
    push(1'b1, 2'd1, 8'h45, 8'h00, 8'h00);
    wait_idle(100);
    check("f_starts", start_cnt - s0, 6);
    check("f_last_addr", int'(pb_addr), 'h45);

    // Response FIFO fills; fifth read stalls in IDLE
    s0 = start_cnt;
    for (int i = 1; i <= 5; i++) push(1'b0, 2'd3, 8'(i), 8'h00, 8'h00);
    repeat (40) @(negedge clk);
    check("q_starts4", start_cnt - s0, 4);
    check("q_stall_busy", int'(busy), 1);
    check("q_head", int'({rsp_valid, rsp_sel, rsp_data}), int'({1'b1, 2'd3, 8'h7D}));
    pop_rsp();
    wait_idle(40);
    check("q_starts5", start_cnt - s0, 5);
    for (int i = 0; i < 4; i++) begin
      check("q_data", int'(rsp_data), int'(exp_rd[i]));
      pop_rsp();
    end
    check("q_empty", int'(rsp_valid), 0);

`ifdef APB_SEQ_TIMEOUT_EN
    // Watchdog: TIMEOUT=8 cycles of WAIT without ready
    resp_en = 1'b0;
    push(1'b1, 2'd1, 8'h60, 8'h00, 8'h00);
    wait_start(10);
    repeat (8) @(negedge clk);
    check("t_pre", int'({pb_reset, err_timeout}), 0);
    @(negedge clk);
    check("t_pulse", int'({pb_reset, err_timeout}), 3);
    check("t_idle_sel", int'(pb_sel), 0);
    @(negedge clk);
    check("t_pulse_end", int'(pb_reset), 0);
    check("t_no_rsp", int'(rsp_valid), 0);
    resp_en = 1'b1;
    push(1'b1, 2'd2, 8'h61, 8'h00, 8'h00);
    wait_start(10);
    check("t_next_addr", int'(pb_addr), 'h61);
    wait_idle(20);
    check("t_sticky", int'(err_timeout), 1);
`endif

    // Reset in the middle of a read WAIT, with a ready pulse pending
    resp_en = 1'b0;
    push(1'b0, 2'd2, 8'h70, 8'h00, 8'h00);
    wait_start(10);
    @(negedge clk);
    kick = 1'b1; reset = 1'b0;
    @(negedge clk);
    check("m_start", int'(pb_start), 0);
    check("m_fields", int'({pb_write, pb_sel, pb_addr, pb_wdata, pb_wait_cycles}), 0);
    check("m_ctrl", int'({busy, cmd_ready, pb_reset}), 1);
    check("m_err", int'({err_sel, err_timeout}), 0);
    check("m_rsp", int'(rsp_valid), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("m_after", int'({rsp_valid, busy, cmd_ready}), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
